// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf
// ---------------------------------------------------------------------------
// Ping-pong reorder buffer for the output of the radix-2 SDF FFT. Each input
// frame of 1<<N complex samples is written into one of two banks, either at
// the bit-reversed address of its arrival index (reorder mode) or at the
// arrival index itself (bypass mode). Full banks are read out in address
// order through a valid/ready output register, so reordered frames leave in
// natural order. While one bank drains the other can fill, which gives
// gapless one-sample-per-cycle throughput when the output is never stalled.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready is low only when the
//                         bank the writer would use is still FULL
//   in_sof                sample index 0 of a frame
//   bitrev_en             frame mode, taken with in_sof (1 reorder, 0 bypass)
//   in_re, in_im          input sample components (DW bits, two's complement)
//   out_valid / out_ready output handshake
//   out_sof, out_eof      first / last word of an output frame
//   out_re, out_im        output sample components
//   overflow              registered pulse: in_valid seen while in_ready=0
//   frame_err             registered pulse: sof mid-frame or data with no
//                         frame open
// ---------------------------------------------------------------------------
module fft_reorder_buf #(
  parameter int N  = 3,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          bitrev_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eof,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          overflow,
  output logic          frame_err
);

  localparam int           DEPTH = 1 << N;
  localparam logic [N-1:0] LAST  = N'(DEPTH - 1);

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FULL
  } bank_state_t;

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_t;

  logic [2*DW-1:0] mem [2][DEPTH];
  bank_state_t     bank_state [2];

  wr_state_t       wr_state;
  wr_state_t       wr_state_next;
  logic            wr_bank;
  logic [N-1:0]    wr_k;
  logic            wr_mode;

  logic            rd_bank;
  logic [N-1:0]    rd_addr;

  logic            accept;
  logic            wr_en;
  logic            wr_start;
  logic            wr_done;
  logic [N-1:0]    wr_addr;
  logic            err_next;
  logic            rd_load;
  logic            rd_last;
  logic [2*DW-1:0] rd_word;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i] = v[N-1-i];
    end
    return r;
  endfunction

  // Handshake and read-side decode. A FILLING bank belongs to the writer, so
  // only a FULL bank under the write pointer blocks new input. The output
  // register reloads whenever it is empty or its word is being taken.
  always_comb begin
    in_ready = (bank_state[wr_bank] != BANK_FULL);
    accept   = in_valid && in_ready;
    rd_load  = (bank_state[rd_bank] == BANK_FULL) && (!out_valid || out_ready);
    rd_last  = (rd_addr == LAST);
    rd_word  = mem[rd_bank][rd_addr];
  end

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= WR_IDLE;
    end else begin
      wr_state <= wr_state_next;
    end
  end

  // Write FSM next state: a frame opens on an accepted sof and closes on the
  // last sample. A sof inside a frame restarts it, so the FSM stays in WRITE.
  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (accept && in_sof) begin
          wr_state_next = WR_WRITE;
        end
      end
      WR_WRITE: begin
        if (accept && !in_sof && (wr_k == LAST)) begin
          wr_state_next = WR_IDLE;
        end
      end
      default: wr_state_next = WR_IDLE;
    endcase
  end

  // Write FSM outputs. Sample 0 always lands at address 0 because bitrev(0)=0,
  // so a (re)start writes there regardless of mode. Data outside a frame and a
  // sof inside one both raise frame_err; blocked samples never reach here, so
  // an overflow never doubles as a frame error.
  always_comb begin
    wr_en    = 1'b0;
    wr_start = 1'b0;
    wr_done  = 1'b0;
    wr_addr  = '0;
    err_next = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (accept) begin
          if (in_sof) begin
            wr_en    = 1'b1;
            wr_start = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      WR_WRITE: begin
        if (accept) begin
          if (in_sof) begin
            wr_en    = 1'b1;
            wr_start = 1'b1;
            err_next = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = wr_mode ? bitrev(wr_k) : wr_k;
            wr_done = (wr_k == LAST);
          end
        end
      end
      default: begin
        err_next = 1'b0;
      end
    endcase
  end

  // Write-side bookkeeping: sample counter, latched mode and bank pointer.
  // The counter wraps to zero on the last sample, ready for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_k    <= '0;
      wr_mode <= 1'b0;
      wr_bank <= 1'b0;
    end else begin
      if (wr_start) begin
        wr_k    <= N'(1);
        wr_mode <= bitrev_en;
      end else if (wr_en) begin
        wr_k <= wr_k + N'(1);
      end
      if (wr_done) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank ownership. The writer only touches a non-FULL bank and the reader
  // only a FULL one, so the two updates never target the same bank in one
  // cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_state[0] <= BANK_FREE;
      bank_state[1] <= BANK_FREE;
    end else begin
      if (wr_start) begin
        bank_state[wr_bank] <= BANK_FILLING;
      end
      if (wr_done) begin
        bank_state[wr_bank] <= BANK_FULL;
      end
      if (rd_load && rd_last) begin
        bank_state[rd_bank] <= BANK_FREE;
      end
    end
  end

  // Sample storage; contents are left alone on reset since bank state alone
  // decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= {in_re, in_im};
    end
  end

  // Output register and read pointer. Holding the register while stalled
  // keeps data, sof and eof stable until the downstream takes the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      rd_addr   <= '0;
      rd_bank   <= 1'b0;
    end else begin
      if (rd_load) begin
        out_valid <= 1'b1;
        out_re    <= rd_word[2*DW-1:DW];
        out_im    <= rd_word[DW-1:0];
        out_sof   <= (rd_addr == '0);
        out_eof   <= rd_last;
        rd_addr   <= rd_addr + N'(1);
        if (rd_last) begin
          rd_bank <= ~rd_bank;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Error pulses are registered so they appear the cycle after the offending
  // input.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= in_valid && !in_ready;
      frame_err <= err_next;
    end
  end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf
// ---------------------------------------------------------------------------
// Bench for fft_reorder_buf (N=3, DW=16). A directed table covers the first
// reordered frame cycle by cycle, hand-written sequences cover bypass,
// back-to-back frames, overflow, frame errors and reset mid-output, and a
// randomized run closes things out. A queue-based reference model of the
// buffer predicts every output in every cycle.
// ---------------------------------------------------------------------------
module tb_fft_reorder_buf;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int FL = 1 << N;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          bitrev_en;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eof;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          overflow;
  logic          frame_err;

  always #5 clk = ~clk;

  fft_reorder_buf #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .bitrev_en (bitrev_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_re    (out_re),
    .out_im    (out_im),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Output-stream statistics for the gapless checks.
  int valid_seen     = 0;
  int cur_run        = 0;
  int max_run        = 0;
  int ready_low_seen = 0;

  // Reference model: complete frames are kept as a word queue already in
  // output order; the front frame stays "held" until its last word leaves.
  logic [2*DW-1:0] word_q [$];
  logic [2*DW-1:0] m_samples [FL];
  bit              m_writing;
  bit              m_mode;
  int              m_k;
  bit              m_ov;
  bit              m_sof;
  bit              m_eof;
  bit              m_ovf;
  bit              m_ferr;
  logic [DW-1:0]   m_re;
  logic [DW-1:0]   m_im;

  int exp_order [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct {
    bit            iv;
    bit            isof;
    bit            ibr;
    logic [DW-1:0] ire;
    logic [DW-1:0] iim;
    bit            ordy;
    bit            e_ov;
    bit            e_rdy;
    logic [DW-1:0] e_re;
    logic [DW-1:0] e_im;
    bit            e_sof;
    bit            e_eof;
  } vec_t;

  vec_t tbl [17];

  function automatic int revIndex(input int j);
    int r = 0;
    int v = j;
    for (int b = 0; b < N; b++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  function automatic int heldFrames();
    return (word_q.size() + FL - 1) / FL;
  endfunction

  task automatic modelStep(input bit iv, input bit isof, input bit ibr,
                           input logic [DW-1:0] ire, input logic [DW-1:0] iim,
                           input bit ordy, input bit rst);
    bit              rdy;
    int              pos;
    logic [2*DW-1:0] w;
    if (rst) begin
      word_q.delete();
      m_writing = 0;
      m_k       = 0;
      m_ov      = 0;
      m_sof     = 0;
      m_eof     = 0;
      m_re      = '0;
      m_im      = '0;
      m_ovf     = 0;
      m_ferr    = 0;
      return;
    end
    rdy    = heldFrames() < 2;
    m_ovf  = iv && !rdy;
    m_ferr = 0;
    if (heldFrames() > 0 && (!m_ov || ordy)) begin
      pos   = (FL - word_q.size() % FL) % FL;
      w     = word_q.pop_front();
      m_ov  = 1;
      m_re  = w[2*DW-1:DW];
      m_im  = w[DW-1:0];
      m_sof = (pos == 0);
      m_eof = (pos == FL - 1);
    end else if (ordy) begin
      m_ov = 0;
    end
    if (iv && rdy) begin
      if (isof) begin
        m_ferr       = m_writing;
        m_writing    = 1;
        m_mode       = ibr;
        m_samples[0] = {ire, iim};
        m_k          = 1;
      end else if (!m_writing) begin
        m_ferr = 1;
      end else begin
        m_samples[m_k] = {ire, iim};
        if (m_k == FL - 1) begin
          for (int j = 0; j < FL; j++) begin
            word_q.push_back(m_mode ? m_samples[revIndex(j)] : m_samples[j]);
          end
          m_writing = 0;
        end else begin
          m_k++;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareToModel();
    checkOutput("out_valid", 64'(out_valid), 64'(m_ov));
    checkOutput("in_ready", 64'(in_ready), 64'(heldFrames() < 2));
    checkOutput("overflow", 64'(overflow), 64'(m_ovf));
    checkOutput("frame_err", 64'(frame_err), 64'(m_ferr));
    if (m_ov) begin
      checkOutput("out_re", 64'(out_re), 64'(m_re));
      checkOutput("out_im", 64'(out_im), 64'(m_im));
      checkOutput("out_sof", 64'(out_sof), 64'(m_sof));
      checkOutput("out_eof", 64'(out_eof), 64'(m_eof));
    end
  endtask

  // One clock cycle: drive inputs, advance the model, sample #1 after the edge.
  task automatic applyStimulus(input bit iv, input bit isof, input bit ibr,
                               input logic [DW-1:0] ire, input logic [DW-1:0] iim,
                               input bit ordy, input bit rst);
    in_valid  = iv;
    in_sof    = isof;
    bitrev_en = ibr;
    in_re     = ire;
    in_im     = iim;
    out_ready = ordy;
    reset     = rst;
    modelStep(iv, isof, ibr, ire, iim, ordy, rst);
    @(posedge clk);
    #1;
    compareToModel();
    if (out_valid) begin
      valid_seen++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else begin
      cur_run = 0;
    end
    if (!in_ready) ready_low_seen++;
  endtask

  // Non-sof samples carry the opposite mode to show the mode is latched.
  task automatic sendFrame(input bit mode, input int base, input bit ordy);
    for (int k = 0; k < FL; k++) begin
      applyStimulus(1, k == 0, (k == 0) ? mode : !mode, DW'(base + k),
                    DW'(-(base + k)), ordy, 0);
    end
  endtask

  task automatic idleCycles(input int n, input bit ordy);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, '0, '0, ordy, 0);
    end
  endtask

  initial begin
    int kk;
    bit iv;
    bit sf;

    // Directed table: one reordered frame, re=k, im=-k, output always ready.
    for (int i = 0; i < 17; i++) begin
      tbl[i].iv    = (i < 8);
      tbl[i].isof  = (i == 0);
      tbl[i].ibr   = 1;
      tbl[i].ire   = (i < 8) ? DW'(i) : '0;
      tbl[i].iim   = (i < 8) ? DW'(-i) : '0;
      tbl[i].ordy  = 1;
      tbl[i].e_ov  = (i >= 8 && i <= 15);
      tbl[i].e_rdy = 1;
      tbl[i].e_re  = (i >= 8 && i <= 15) ? DW'(exp_order[i-8]) : '0;
      tbl[i].e_im  = (i >= 8 && i <= 15) ? DW'(-exp_order[i-8]) : '0;
      tbl[i].e_sof = (i == 8);
      tbl[i].e_eof = (i == 15);
    end

    applyStimulus(0, 0, 0, '0, '0, 0, 1);
    applyStimulus(0, 0, 0, '0, '0, 0, 1);
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_re", 64'(out_re), 64'(0));
    checkOutput("rst_out_im", 64'(out_im), 64'(0));
    checkOutput("rst_sof_eof", 64'({out_sof, out_eof}), 64'(0));

    $display("[TB] directed reorder frame");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].iv, tbl[i].isof, tbl[i].ibr, tbl[i].ire, tbl[i].iim,
                    tbl[i].ordy, 0);
      checkOutput($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      checkOutput($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      if (tbl[i].e_ov) begin
        checkOutput($sformatf("tbl%0d_out_re", i), 64'(out_re), 64'(tbl[i].e_re));
        checkOutput($sformatf("tbl%0d_out_im", i), 64'(out_im), 64'(tbl[i].e_im));
        checkOutput($sformatf("tbl%0d_out_sof", i), 64'(out_sof), 64'(tbl[i].e_sof));
        checkOutput($sformatf("tbl%0d_out_eof", i), 64'(out_eof), 64'(tbl[i].e_eof));
      end
    end

    $display("[TB] bypass and alternating modes");
    sendFrame(0, 16'h0010, 1);
    idleCycles(12, 1);
    sendFrame(1, 16'h0020, 1);
    sendFrame(0, 16'h0030, 1);
    idleCycles(20, 1);

    $display("[TB] four back-to-back frames");
    valid_seen     = 0;
    cur_run        = 0;
    max_run        = 0;
    ready_low_seen = 0;
    for (int f = 0; f < 4; f++) begin
      sendFrame(f[0], 16'h0100 + f * 16, 1);
    end
    idleCycles(12, 1);
    checkOutput("t3_words", 64'(valid_seen), 64'(32));
    checkOutput("t3_gapless_run", 64'(max_run), 64'(32));
    checkOutput("t3_ready_low", 64'(ready_low_seen), 64'(0));

    $display("[TB] stalled output and overflow");
    sendFrame(1, 16'h0200, 0);
    sendFrame(0, 16'h0300, 0);
    checkOutput("t4_ready_low", 64'(in_ready), 64'(0));
    applyStimulus(1, 0, 0, 16'h0777, 16'h0888, 0, 0);
    checkOutput("t4_overflow", 64'(overflow), 64'(1));
    checkOutput("t4_no_ferr", 64'(frame_err), 64'(0));
    idleCycles(30, 1);

    $display("[TB] sof mid-frame and data before sof");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, k == 0, 1, DW'(16'h0400 + k), DW'(16'h0500 + k), 1, 0);
    end
    for (int k = 0; k < FL; k++) begin
      applyStimulus(1, k == 0, 1, DW'(16'h0600 + k), DW'(16'h0700 + k), 1, 0);
      if (k == 0) checkOutput("t5_restart_ferr", 64'(frame_err), 64'(1));
    end
    idleCycles(20, 1);
    applyStimulus(0, 0, 0, '0, '0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 1, DW'(16'h0900 + k), DW'(16'h0a00 + k), 1, 0);
      if (k == 0) checkOutput("t5_nosof_ferr", 64'(frame_err), 64'(1));
    end
    idleCycles(15, 1);

    $display("[TB] reset during output");
    sendFrame(1, 16'h0b00, 0);
    sendFrame(1, 16'h0c00, 0);
    idleCycles(3, 1);
    applyStimulus(0, 0, 0, '0, '0, 1, 1);
    checkOutput("t6_out_valid", 64'(out_valid), 64'(0));
    checkOutput("t6_in_ready", 64'(in_ready), 64'(1));
    idleCycles(30, 1);

    $display("[TB] randomized traffic");
    kk = 0;
    for (int c = 0; c < 600; c++) begin
      iv = ($urandom_range(0, 9) < 7);
      sf = (kk == 0) || ($urandom_range(0, 99) == 0);
      if (iv) kk = sf ? 1 : (kk + 1) % FL;
      applyStimulus(iv, sf, 1'($urandom), DW'($urandom), DW'($urandom),
                    ($urandom_range(0, 9) < 6), 0);
    end
    idleCycles(40, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
